arb_rr_oht: RTL



---
 rtl/arb_rr_oht_pkg.sv | 25 ++
 rtl/bin2oht_tree.sv | 42 ++++
 rtl/arb_rr_oht.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/arb_rr_oht_pkg.sv
// Shared types and helpers for the round-robin arbiter with locked grants
// and its one-hot decoder tree.
package arb_rr_oht_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // One branch of a decoder node: is output k selected by this digit?
    // impl 0 compares the digit directly; any other value uses a shifted mask.
    function automatic logic dec_digit(input int digit, input int k, input int impl);
        logic [31:0] w_sh;
        logic        w_hit;
        w_sh = 32'd0;
        if (impl == 0) begin
            w_hit = (digit == k);
        end else begin
            w_sh  = 32'd1 << digit;
            w_hit = w_sh[k];
        end
        return w_hit;
    endfunction

endpackage

// File: rtl/bin2oht_tree.sv
// Binary-to-one-hot decoder built as a SPLIT-ary tree; one level per index digit.
// SPLIT is expected to be a power of two and WIDTH a power of SPLIT.
module bin2oht_tree
    import arb_rr_oht_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int SPLIT          = 2,
    parameter int IMPLEMENTATION = 0
) (
    input  logic                     vld,
    input  logic [$clog2(WIDTH)-1:0] bin,
    output logic [WIDTH-1:0]         oht
);

    localparam int WIDTH_LOG = $clog2(WIDTH);
    localparam int DB        = (SPLIT > 1) ? $clog2(SPLIT) : 1;
    localparam int LEVELS    = WIDTH_LOG / DB;

    logic [WIDTH-1:0] w_cur;
    logic [WIDTH-1:0] w_nxt;
    int               w_digit;

    // Expand the enable one level per digit, most significant digit first.
    always_comb begin
        w_cur    = {WIDTH{1'b0}};
        w_cur[0] = vld;
        w_nxt    = {WIDTH{1'b0}};
        w_digit  = 0;
        for (int l = 0; l < LEVELS; l++) begin
            w_digit = (int'(bin) >> ((LEVELS - 1 - l) * DB)) & (SPLIT - 1);
            w_nxt   = {WIDTH{1'b0}};
            for (int j = 0; j < WIDTH / SPLIT; j++) begin
                for (int k = 0; k < SPLIT; k++) begin
                    w_nxt[j*SPLIT+k] = w_cur[j] & dec_digit(w_digit, k, IMPLEMENTATION);
                end
            end
            w_cur = w_nxt;
        end
        oht = w_cur;
    end

endmodule

// File: rtl/arb_rr_oht.sv
// Round-robin arbiter: a grant is locked until ack or an optional hold timeout,
// then re-arbitrated in the same cycle; grant is output as index and one-hot.
module arb_rr_oht
    import arb_rr_oht_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int SPLIT          = 2,
    parameter int IMPLEMENTATION = 0,
    parameter int HOLD_MAX       = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         req,
    input  logic                     ack,
    output logic                     gnt_vld,
    output logic [$clog2(WIDTH)-1:0] gnt_bin,
    output logic [WIDTH-1:0]         gnt_oht,
    output logic                     tmo
);

    localparam int WIDTH_LOG = $clog2(WIDTH);

    arb_state_e           r_state;
    logic [WIDTH_LOG-1:0] r_bin;
    logic [WIDTH_LOG-1:0] r_ptr;

    arb_state_e           w_state_nxt;
    logic [WIDTH_LOG-1:0] w_bin_nxt;
    logic [WIDTH_LOG-1:0] w_ptr_nxt;
    logic [WIDTH_LOG-1:0] w_win;
    logic                 w_any;
    logic                 w_load;
    logic                 w_release;
    logic                 w_tmo_hit;

    // First requester after p, wrapping; p itself is considered last.
    function automatic logic [WIDTH_LOG-1:0] rr_pick(input logic [WIDTH-1:0] r,
                                                     input logic [WIDTH_LOG-1:0] p);
        logic [WIDTH_LOG-1:0] win;
        int                   c;
        win = {WIDTH_LOG{1'b0}};
        for (int i = WIDTH; i >= 1; i--) begin
            c = (int'(p) + i) % WIDTH;
            if (r[c]) begin
                win = WIDTH_LOG'(c);
            end else begin
                win = win;
            end
        end
        return win;
    endfunction

    assign w_any = |req;
    assign w_win = rr_pick(req, r_ptr);

    // Next-state: grant from idle, or release (ack/timeout) with re-arbitration.
    always_comb begin
        w_state_nxt = r_state;
        w_bin_nxt   = r_bin;
        w_ptr_nxt   = r_ptr;
        w_load      = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_GRANT;
                    w_bin_nxt   = w_win;
                    w_ptr_nxt   = w_win;
                    w_load      = 1'b1;
                end else begin
                    w_bin_nxt   = {WIDTH_LOG{1'b0}};
                end
            end
            ST_GRANT: begin
                if (ack || w_tmo_hit) begin
                    w_release = 1'b1;
                    if (w_any) begin
                        w_bin_nxt = w_win;
                        w_ptr_nxt = w_win;
                        w_load    = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_bin_nxt   = {WIDTH_LOG{1'b0}};
                    end
                end else begin
                    w_release = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_bin_nxt   = {WIDTH_LOG{1'b0}};
            end
        endcase
    end

    // Grant state, index and priority pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_bin   <= {WIDTH_LOG{1'b0}};
            r_ptr   <= WIDTH_LOG'(WIDTH - 1);
        end else begin
            r_state <= w_state_nxt;
            r_bin   <= w_bin_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    generate
        if (HOLD_MAX > 0) begin : g_hold
            localparam int HOLD_LOG = $clog2(HOLD_MAX + 1);
            logic [HOLD_LOG-1:0] r_cnt;
            logic                r_tmo;

            // A grant that reaches its last allowed cycle without ack is released.
            assign w_tmo_hit = (r_state == ST_GRANT) && !ack &&
                               (r_cnt == HOLD_LOG'(HOLD_MAX - 1));

            // Cycles elapsed in the current grant, plus the one-cycle timeout flag.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= {HOLD_LOG{1'b0}};
                    r_tmo <= 1'b0;
                end else begin
                    r_tmo <= w_tmo_hit;
                    if (w_load) begin
                        r_cnt <= {HOLD_LOG{1'b0}};
                    end else if ((r_state == ST_GRANT) && !w_release) begin
                        r_cnt <= r_cnt + HOLD_LOG'(1);
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
            end

            assign tmo = r_tmo;
        end else begin : g_nohold
            assign w_tmo_hit = 1'b0;
            assign tmo       = 1'b0;
        end
    endgenerate

    assign gnt_vld = (r_state == ST_GRANT);
    assign gnt_bin = r_bin;

    bin2oht_tree #(
        .WIDTH          (WIDTH),
        .SPLIT          (SPLIT),
        .IMPLEMENTATION (IMPLEMENTATION)
    ) u_dec (
        .vld (gnt_vld),
        .bin (gnt_bin),
        .oht (gnt_oht)
    );

endmodule
